// File: rtl/data_mem_mmio.sv
// Data-memory subsystem for the accumulator CPU core.
// 0x00-0xEF is a 240-byte RAM; 0xF0-0xFF holds memory-mapped peripherals:
// LED register, synchronised switches, prescaled timer with wrap flag and
// a TX byte FIFO that drains over a ready/valid stream.
module data_mem_mmio #(
    parameter int PRESCALE   = 1000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       _iClk,
    input  logic       _iReset,
    input  logic [7:0] _iAddr,
    input  logic [7:0] _iWData,
    input  logic       _iWrite,
    output logic [7:0] _oRData,
    input  logic [7:0] _iSwitches,
    output logic [7:0] _oLeds,
    output logic [7:0] _oTxData,
    output logic       _oTxValid,
    input  logic       _iTxReady
);

    // Prescaler needs at least one bit even when PRESCALE is 1.
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [3:0]      CNT_FULL = 4'(FIFO_DEPTH);

    localparam logic [7:0] ADDR_LED    = 8'hF0;
    localparam logic [7:0] ADDR_SW     = 8'hF1;
    localparam logic [7:0] ADDR_TIMER  = 8'hF2;
    localparam logic [7:0] ADDR_TFLAG  = 8'hF3;
    localparam logic [7:0] ADDR_TXDATA = 8'hF4;
    localparam logic [7:0] ADDR_STATUS = 8'hF5;
    localparam logic [7:0] ADDR_MMIO   = 8'hF0;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [7:0]       ram_q [0:239];
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];

    logic [7:0]       leds_q, leds_d;
    logic [7:0]       sw_meta_q, sw_sync_q;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic [7:0]       timer_q, timer_d;
    logic             flag_q, flag_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // ------------------------------------------------------------------
    // Address decode (writes only act for one cycle, on _iWrite)
    // ------------------------------------------------------------------
    logic is_ram;
    logic wr_ram, wr_led, wr_timer, wr_tflag, wr_txdata, wr_status;

    assign is_ram    = (_iAddr < ADDR_MMIO);
    assign wr_ram    = _iWrite && is_ram;
    assign wr_led    = _iWrite && (_iAddr == ADDR_LED);
    assign wr_timer  = _iWrite && (_iAddr == ADDR_TIMER);
    assign wr_tflag  = _iWrite && (_iAddr == ADDR_TFLAG);
    assign wr_txdata = _iWrite && (_iAddr == ADDR_TXDATA);
    assign wr_status = _iWrite && (_iAddr == ADDR_STATUS);

    // ------------------------------------------------------------------
    // TX stream handshake: _oTxValid is high whenever the FIFO holds a
    // byte and _oTxData is that head byte; a transfer happens on every
    // rising edge where _oTxValid and _iTxReady are both high. Valid
    // never depends on ready, and the head byte is stable until popped.
    // ------------------------------------------------------------------
    logic fifo_empty, fifo_full;
    logic pop, push, ovf_set;

    assign fifo_empty = (cnt_q == 4'd0);
    assign fifo_full  = (cnt_q == CNT_FULL);
    assign _oTxValid  = !fifo_empty;
    assign _oTxData   = fifo_empty ? 8'h00 : fifo_mem_q[rptr_q];
    assign pop        = _oTxValid && _iTxReady;
    // A pop on the same edge frees the slot a full FIFO would otherwise lack.
    assign push       = wr_txdata && (!fifo_full || pop);
    assign ovf_set    = wr_txdata && fifo_full && !pop;

    assign _oLeds = leds_q;

    // RAM write port; contents survive reset.
    always_ff @(posedge _iClk) begin
        if (wr_ram) begin
            ram_q[_iAddr] <= _iWData;
        end
    end

    // FIFO data storage; only the pointers and count are reset.
    always_ff @(posedge _iClk) begin
        if (push) begin
            fifo_mem_q[wptr_q] <= _iWData;
        end
    end

    // Next-state for LEDs, timer/prescaler/flag and FIFO bookkeeping.
    always_comb begin
        leds_d  = leds_q;
        ps_d    = ps_q;
        timer_d = timer_q;
        flag_d  = flag_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (wr_led) begin
            leds_d = _iWData;
        end

        // Software clear first so a same-edge wrap can override it.
        if (wr_tflag && _iWData[0]) begin
            flag_d = 1'b0;
        end

        // A TIMER write suppresses any increment due on this edge.
        if (wr_timer) begin
            timer_d = _iWData;
            ps_d    = '0;
        end else if (ps_q == PS_LAST) begin
            ps_d    = '0;
            timer_d = timer_q + 8'd1;
            if (timer_q == 8'hFF) begin
                flag_d = 1'b1;
            end
        end else begin
            ps_d = ps_q + 1'b1;
        end

        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase

        if (wr_status && _iWData[2]) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge _iClk) begin
        if (_iReset) begin
            leds_q    <= 8'h00;
            sw_meta_q <= 8'h00;
            sw_sync_q <= 8'h00;
            ps_q      <= '0;
            timer_q   <= 8'h00;
            flag_q    <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= 4'd0;
            ovf_q     <= 1'b0;
        end else begin
            leds_q    <= leds_d;
            sw_meta_q <= _iSwitches;
            sw_sync_q <= sw_meta_q;
            ps_q      <= ps_d;
            timer_q   <= timer_d;
            flag_q    <= flag_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Combinational read mux; reads never change state.
    always_comb begin
        _oRData = 8'h00;
        if (is_ram) begin
            _oRData = ram_q[_iAddr];
        end else begin
            case (_iAddr)
                ADDR_LED:    _oRData = leds_q;
                ADDR_SW:     _oRData = sw_sync_q;
                ADDR_TIMER:  _oRData = timer_q;
                ADDR_TFLAG:  _oRData = {7'b0, flag_q};
                ADDR_TXDATA: _oRData = 8'h00;
                ADDR_STATUS: _oRData = {cnt_q, 1'b0, ovf_q, fifo_full, fifo_empty};
                default:     _oRData = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Bench for data_mem_mmio: directed scenarios plus a randomized run
// checked against a transaction-level model of the memory map.
module tb_data_mem_mmio;

    localparam int PS    = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       write;
    logic [7:0] rdata;
    logic [7:0] sw;
    logic [7:0] leds;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    int tests = 0;
    int fails = 0;

    // Clock generation
    always #5 clk = ~clk;

    data_mem_mmio #(.PRESCALE(PS), .FIFO_DEPTH(DEPTH)) dut (
        ._iClk      (clk),
        ._iReset    (rst),
        ._iAddr     (addr),
        ._iWData    (wdata),
        ._iWrite    (write),
        ._oRData    (rdata),
        ._iSwitches (sw),
        ._oLeds     (leds),
        ._oTxData   (tx_data),
        ._oTxValid  (tx_valid),
        ._iTxReady  (tx_ready)
    );

    // ------------------------------------------------------------------
    // Reference model: RAM array, timer as load value plus elapsed cycles,
    // FIFO as a queue, switch history as a queue of sampled values.
    // ------------------------------------------------------------------
    logic [7:0] m_ram [256];
    bit         m_ram_ok [256];
    logic [7:0] m_leds = 8'h00;
    int         m_load = 0;
    int         m_cycles = 0;
    bit         m_flag = 1'b0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_fifo [$];
    logic [7:0] m_sw_hist [$] = '{8'h00, 8'h00};

    function automatic logic [7:0] m_timer();
        return 8'((m_load + m_cycles / PS) % 256);
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        int n;
        n = m_fifo.size();
        if (a < 8'hF0) return m_ram[a];
        case (a)
            8'hF0:   return m_leds;
            8'hF1:   return m_sw_hist[0];
            8'hF2:   return m_timer();
            8'hF3:   return {7'b0, m_flag};
            8'hF5:   return {4'(n), 1'b0, m_ovf, (n == DEPTH), (n == 0)};
            default: return 8'h00;
        endcase
    endfunction

    // Apply one rising edge to the model using the inputs the DUT sampled.
    task automatic model_edge();
        int n;
        bit pop;
        if (rst) begin
            m_leds = 8'h00;
            m_load = 0;
            m_cycles = 0;
            m_flag = 1'b0;
            m_ovf = 1'b0;
            m_fifo.delete();
            m_sw_hist = '{8'h00, 8'h00};
            return;
        end
        n = m_fifo.size();
        pop = (n != 0) && tx_ready;
        if (write) begin
            if (addr < 8'hF0) begin
                m_ram[addr] = wdata;
                m_ram_ok[addr] = 1'b1;
            end
            if (addr == 8'hF0) m_leds = wdata;
            if (addr == 8'hF3 && wdata[0]) m_flag = 1'b0;
            if (addr == 8'hF5 && wdata[2]) m_ovf = 1'b0;
        end
        if (write && addr == 8'hF2) begin
            m_load = int'(wdata);
            m_cycles = 0;
        end else begin
            m_cycles++;
            if (m_cycles % PS == 0 && m_timer() == 8'h00) m_flag = 1'b1;
        end
        if (pop) void'(m_fifo.pop_front());
        if (write && addr == 8'hF4) begin
            if (n < DEPTH || pop) m_fifo.push_back(wdata);
            else m_ovf = 1'b1;
        end
        m_sw_hist.push_back(sw);
        void'(m_sw_hist.pop_front());
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a;
        wdata = d;
        write = 1'b1;
        step();
        write = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        addr = 8'hF5;
        #1;
        tests++; if (rdata !== 8'h01) begin fails++; $display("FAIL reset_status: got %02h expected 01", rdata); end
        tests++; if (leds !== 8'h00) begin fails++; $display("FAIL reset_leds: got %02h expected 00", leds); end
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", tx_valid); end
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_txdata: got %02h expected 00", tx_data); end
        addr = 8'hF2;
        #1;
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL reset_timer: got %02h expected 00", rdata); end
        addr = 8'hF3;
        #1;
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL reset_flag: got %02h expected 00", rdata); end
    endtask

    task automatic test_ram();
        wr(8'h10, 8'h5A);
        wr(8'hEF, 8'hA5);
        addr = 8'h10;
        #1;
        tests++; if (rdata !== 8'h5A) begin fails++; $display("FAIL ram_10: got %02h expected 5a", rdata); end
        addr = 8'hEF;
        #1;
        tests++; if (rdata !== 8'hA5) begin fails++; $display("FAIL ram_ef: got %02h expected a5", rdata); end
        addr = 8'hF8;
        #1;
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL unmapped_f8: got %02h expected 00", rdata); end
    endtask

    task automatic test_leds_switches();
        tests++; if (leds !== 8'h00) begin fails++; $display("FAIL leds_idle: got %02h expected 00", leds); end
        wr(8'hF0, 8'h3C);
        tests++; if (leds !== 8'h3C) begin fails++; $display("FAIL leds_write: got %02h expected 3c", leds); end
        addr = 8'hF0;
        #1;
        tests++; if (rdata !== 8'h3C) begin fails++; $display("FAIL leds_read: got %02h expected 3c", rdata); end
        sw = 8'h81;
        addr = 8'hF1;
        #1;
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL sw_edge0: got %02h expected 00", rdata); end
        step();
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL sw_edge1: got %02h expected 00", rdata); end
        step();
        tests++; if (rdata !== 8'h81) begin fails++; $display("FAIL sw_edge2: got %02h expected 81", rdata); end
    endtask

    task automatic test_timer();
        rst = 1'b1;
        step();
        rst = 1'b0;
        addr = 8'hF2;
        step();
        step();
        tests++; if (rdata !== 8'h01) begin fails++; $display("FAIL timer_first: got %02h expected 01", rdata); end
        wr(8'hF2, 8'hFE);
        tests++; if (rdata !== 8'hFE) begin fails++; $display("FAIL timer_load: got %02h expected fe", rdata); end
        repeat (4) step();
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL timer_wrap: got %02h expected 00", rdata); end
        addr = 8'hF3;
        #1;
        tests++; if (rdata !== 8'h01) begin fails++; $display("FAIL tflag_set: got %02h expected 01", rdata); end
        wr(8'hF3, 8'h01);
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL tflag_clear: got %02h expected 00", rdata); end
    endtask

    task automatic test_fifo_overflow();
        tx_ready = 1'b0;
        wr(8'hF4, 8'h11);
        wr(8'hF4, 8'h22);
        wr(8'hF4, 8'h33);
        wr(8'hF4, 8'h44);
        addr = 8'hF5;
        #1;
        tests++; if (rdata !== 8'h42) begin fails++; $display("FAIL fifo_full_status: got %02h expected 42", rdata); end
        tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin fails++; $display("FAIL fifo_head: got %0b/%02h expected 1/11", tx_valid, tx_data); end
        wr(8'hF4, 8'h55);
        addr = 8'hF5;
        #1;
        tests++; if (rdata !== 8'h46) begin fails++; $display("FAIL fifo_ovf_status: got %02h expected 46", rdata); end
        wr(8'hF5, 8'h04);
        tests++; if (rdata !== 8'h42) begin fails++; $display("FAIL fifo_ovf_clear: got %02h expected 42", rdata); end
    endtask

    task automatic test_fifo_drain();
        logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        addr = 8'hF5;
        tx_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
                fails++;
                $display("FAIL drain_byte%0d: got %0b/%02h expected 1/%02h", i, tx_valid, tx_data, exp_b[i]);
            end
            step();
        end
        tx_ready = 1'b0;
        #1;
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL drain_valid: got %0b expected 0", tx_valid); end
        tests++; if (rdata !== 8'h01) begin fails++; $display("FAIL drain_status: got %02h expected 01", rdata); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
        tx_ready = 1'b0;
        wr(8'hF4, 8'h11);
        wr(8'hF4, 8'h22);
        wr(8'hF4, 8'h33);
        wr(8'hF4, 8'h44);
        addr = 8'hF4;
        wdata = 8'h66;
        write = 1'b1;
        tx_ready = 1'b1;
        step();
        write = 1'b0;
        tx_ready = 1'b0;
        addr = 8'hF5;
        #1;
        tests++; if (rdata !== 8'h42) begin fails++; $display("FAIL pushpop_status: got %02h expected 42", rdata); end
        tx_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
                fails++;
                $display("FAIL pushpop_byte%0d: got %0b/%02h expected 1/%02h", i, tx_valid, tx_data, exp_b[i]);
            end
            step();
        end
        tx_ready = 1'b0;
        #1;
        tests++; if (rdata !== 8'h01) begin fails++; $display("FAIL pushpop_empty: got %02h expected 01", rdata); end
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b0;
        wr(8'hF4, 8'hA1);
        wr(8'hF4, 8'hA2);
        wr(8'hF4, 8'hA3);
        repeat (3) step();
        addr = 8'hF5;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        tests++; if (rdata !== 8'h01) begin fails++; $display("FAIL midrst_status: got %02h expected 01", rdata); end
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %0b expected 0", tx_valid); end
        addr = 8'hF2;
        #1;
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL midrst_timer: got %02h expected 00", rdata); end
        addr = 8'h10;
        #1;
        tests++; if (rdata !== 8'h5A) begin fails++; $display("FAIL midrst_ram10: got %02h expected 5a", rdata); end
        addr = 8'hEF;
        #1;
        tests++; if (rdata !== 8'hA5) begin fails++; $display("FAIL midrst_ramef: got %02h expected a5", rdata); end
    endtask

    task automatic test_random();
        logic [7:0] exp_rd;
        logic [7:0] exp_tx;
        int sel;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst = ($urandom_range(0, 199) == 0);
            write = rst ? 1'b0 : ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 3);
            if (sel == 0) addr = 8'($urandom_range(0, 255));
            else if (sel == 1) addr = 8'($urandom_range(0, 15));
            else addr = 8'hF0 + 8'($urandom_range(0, 15));
            wdata = 8'($urandom);
            if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
            tx_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (!(addr < 8'hF0 && !m_ram_ok[addr])) begin
                exp_rd = m_read(addr);
                tests++;
                if (rdata !== exp_rd) begin
                    fails++;
                    $display("FAIL rand_rdata@%02h cyc%0d: got %02h expected %02h", addr, cyc, rdata, exp_rd);
                end
            end
            tests++;
            if (leds !== m_leds) begin
                fails++;
                $display("FAIL rand_leds cyc%0d: got %02h expected %02h", cyc, leds, m_leds);
            end
            exp_tx = (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
            tests++;
            if (tx_valid !== (m_fifo.size() != 0) || tx_data !== exp_tx) begin
                fails++;
                $display("FAIL rand_tx cyc%0d: got %0b/%02h expected %0b/%02h", cyc, tx_valid, tx_data, (m_fifo.size() != 0), exp_tx);
            end
            step();
        end
        rst = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        addr = 8'h00;
        wdata = 8'h00;
        write = 1'b0;
        sw = 8'h00;
        tx_ready = 1'b0;
        for (int i = 0; i < 256; i++) m_ram_ok[i] = 1'b0;
        test_reset();
        test_ram();
        test_leds_switches();
        test_timer();
        test_fifo_overflow();
        test_fifo_drain();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
- Data-memory subsystem directly downstream of the accumulator CPU core; consumes its data-memory address/write-data/write-strobe and returns read data.
- 0x00–0xEF: 240-byte RAM. 0xF0–0xFF: memory-mapped peripherals (LED register, synchronised switches, prescaled timer with wrap flag, and a TX byte FIFO).
- The TX FIFO drains over a ready/valid stream to a downstream consumer.

Parameters:
- PRESCALE, 1000: clock cycles per timer increment (≥1).
- FIFO_DEPTH, 4: TX FIFO entries (2..15, power of two).

Ports:
- _iClk  input  1  system clock.
- _iReset  input  1  synchronous, active-high reset.
- _iAddr  input  8  data address from CPU; held stable across multiple cycles.
- _iWData  input  8  write data.
- _iWrite  input  1  write strobe; high exactly one cycle per store.
- _oRData  output  8  read data.
- _iSwitches  input  8  asynchronous board switches.
- _oLeds  output  8  LED register.
- _oTxData  output  8  FIFO head byte.
- _oTxValid  output  1  FIFO non-empty.
- _iTxReady  input  1  consumer ready.

Behaviour:
- Interface: one clock, _iClk. Reset is synchronous and active-high on _iReset, sampled on the rising edge of _iClk.
- Reset values:
  - _oLeds=0; timer=0; prescaler=0; timer flag=0; FIFO empty; overflow=0; switch sync flops=0.
  - Hence _oTxValid=0 and _oTxData=0.
  - RAM contents are not affected by reset.
- Read path:
  - _oRData is combinational from _iAddr and current register state, with zero-cycle latency.
  - Reads have no side effects, because the CPU holds the address for several cycles.
- Write path: on a rising edge with _iWrite=1, the addressed location updates. All writes take effect that edge.
- Register map, read behaviour:
  - 0x00–0xEF: RAM byte.
  - 0xF0 LED: current _oLeds.
  - 0xF1 SW: second stage of 2-flop synchroniser on _iSwitches. An input change is visible at the 2nd rising edge after it.
  - 0xF2 TIMER: counter value.
  - 0xF3 TFLAG: {7'b0, flag}.
  - 0xF4 TXDATA: reads 0.
  - 0xF5 STATUS: {count[3:0], 1'b0, overflow, full, empty}.
  - 0xF6–0xFF: read 0.
- Register map, write behaviour:
  - 0x00–0xEF: write stores the byte.
  - 0xF0 LED: write loads the register.
  - 0xF1 SW: write ignored.
  - 0xF2 TIMER: write loads counter=_iWData and prescaler=0.
  - 0xF3 TFLAG: write with bit0=1 clears flag.
  - 0xF4 TXDATA: write pushes into FIFO.
  - 0xF5 STATUS: write with bit2=1 clears overflow.
  - 0xF6–0xFF: writes ignored.
- Timer:
  - Prescaler counts 0..PRESCALE-1. When it equals PRESCALE-1 it returns to 0 and the counter increments mod 256.
  - Increment 0xFF→0x00 sets flag.
  - Flag set and software clear on the same edge: set wins.
  - TIMER write and a pending increment on the same edge: write wins, no increment, flag not set.
- TX FIFO:
  - Circular buffer with read/write pointers that wrap at FIFO_DEPTH, plus count 0..FIFO_DEPTH.
  - _oTxValid = (count≠0); _oTxData = head entry (0 when empty).
  - Pop when _oTxValid & _iTxReady at the edge.
  - Push on TXDATA write if count<FIFO_DEPTH OR a pop occurs the same edge. In that case count is unchanged.
  - Push when full with no pop: byte dropped, overflow set (sticky).
  - Overflow set and clear on the same edge cannot coincide: they are different addresses.
  - empty = (count==0); full = (count==FIFO_DEPTH).
- Reset mid-operation: FIFO contents are discarded and _oTxValid drops at the reset edge. The timer restarts from 0.

Test Plan:
- RAM:
  - Write 0x5A to 0x10 and 0xA5 to 0xEF.
  - Read back 0x5A and 0xA5 combinationally; unwritten 0xF8 reads 0x00.
- LEDs and switches:
  - After reset _oLeds=0x00. Write 0x3C to 0xF0 → _oLeds=0x3C next edge.
  - Drive _iSwitches=0x81 → 0xF1 reads 0x81 from the 2nd edge on, not before.
- Timer (PRESCALE=2):
  - Counter reads 0x01 after 2 cycles.
  - Write 0xFE to 0xF2 → after 4 cycles reads 0x00 and 0xF3 reads 0x01.
  - Write 0x01 to 0xF3 → reads 0x00.
- FIFO fill and overflow:
  - With _iTxReady=0, write 0x11,0x22,0x33,0x44 to 0xF4 → STATUS=0x42.
  - 5th write 0x55 → STATUS=0x46; 0x55 never emitted.
  - Write 0x04 to 0xF5 → STATUS=0x42.
- FIFO drain:
  - Raise _iTxReady → bytes 0x11,0x22,0x33,0x44 on consecutive cycles; then _oTxValid=0 and STATUS=0x01.
  - Full FIFO with simultaneous push 0x66 and pop → no overflow, count stays 4, 0x66 emitted last.
- Reset mid-operation:
  - Assert _iReset with 3 bytes queued and timer running → next edge STATUS=0x01, _oTxValid=0, timer=0x00.
  - RAM contents retained.
